gobang_referee: RTL and testbench
=================================

# gobang_referee

Sequential game controller for the 15x15 five-in-a-row board. Accepts moves through a valid/ready handshake, validates them, and stores black and white stones in two 225-bit bitmaps. After every move it walks the four lines through the new stone, one cell per cycle, and declares a win, a draw, or passes the turn. Its bitmap outputs (index row*15+col) feed the display and the combinational row/column checkers.

## Interface
- BOARD_N, 15, board edge length; cells = BOARD_N*BOARD_N
- WIN_LEN, 5, consecutive stones needed to win
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  new-game pulse; clears board, priority over everything but rst
- mv_valid  in  1  move request
- mv_row  in  4  move row 0..14
- mv_col  in  4  move column 0..14
- mv_ready  out  1  controller can accept a move
- mv_reject  out  1  one-cycle pulse: accepted request was illegal
- board_black  out  225  black stones, bit row*15+col
- board_white  out  225  white stones, bit row*15+col
- turn  out  1  side to move: 0 black, 1 white
- busy  out  1  line scan in progress
- game_over  out  1  game ended
- winner  out  1  valid when game_over && !draw
- draw  out  1  board full without a win
- move_cnt  out  8  stones placed, 0..225

## Operation
- Reset and start values: both bitmaps 0, turn 0, mv_ready 1, mv_reject 0, busy 0, game_over 0, winner 0, draw 0, move_cnt 0. State goes to IDLE.
- States:
  - IDLE: mv_ready=1.
  - SCAN: busy=1.
  - DONE: one cycle, mv_ready=0.
  - OVER: mv_ready=0; only start or rst leaves it.
- Handshake: a transfer happens when mv_valid && mv_ready.
- Illegal move: mv_row>14, mv_col>14, or target cell occupied in either bitmap.
  - mv_reject=1 for one cycle.
  - No state change; turn and move_cnt unchanged; stays in IDLE.
- Legal move:
  - Set the bit in the bitmap selected by turn.
  - move_cnt+1.
  - Latch the coordinates and go to SCAN.
- Scan runs directions in order: H (0,+1), V (+1,0), D (+1,+1), A (+1,-1).
  - Each direction has a negative walk, then a positive walk, each exactly WIN_LEN-1 = 4 cycles.
  - Each walk starts from the latched cell. Each cycle it advances the cursor one step and probes the cell.
  - The walk counter increments only while the walk is unbroken and the probed cell is in bounds and holds the mover's stone.
  - After the first failure the walk is broken. It keeps consuming cycles but adds nothing.
- Run length per direction = 1 + neg + pos, 4 bits, max 9. win_flag is set when run >= WIN_LEN, so overlines count as wins.
- Cursor is signed 5-bit per axis. Out of bounds means <0 or >14, and breaks the walk.
- DONE:
  - win_flag: game_over=1, winner=turn, go to OVER.
  - Else if move_cnt==225: game_over=1, draw=1, go to OVER.
  - Else: toggle turn, go to IDLE.
- A start during SCAN or DONE aborts the scan and clears everything in the same edge.

## Timing
- Accept at cycle T:
  - Stone visible in the bitmap at T+1.
  - busy=1 for T+1..T+32.
  - DONE at T+33.
  - turn, game_over, winner, draw and mv_ready updates visible at T+34.
- Reject at cycle T: mv_reject=1 in cycle T+1 only. mv_ready stays 1, so back-to-back requests are allowed.
- mv_ready is 0 from T+1 through T+33 inclusive.
- start at cycle T: all outputs hold their reset values at T+1. A mv_valid asserted in the same cycle as start is ignored.
- rst and start are identical in effect; rst has precedence.
- Worst-case move-to-decision latency is fixed at 2*4*(WIN_LEN-1)+2 = 34 cycles, with no early exit.

## Structure
- Package gobang_pkg holds:
  - BOARD_N, CELLS, WIN_LEN
  - state enum {IDLE, SCAN, DONE, OVER}
  - direction enum {H, V, D, A} with row/col delta constants
  - cell-index function row*BOARD_N+col
- One sub-module, gobang_cell_probe (combinational):
  - Inputs: signed cursor and a bitmap.
  - Outputs: in_bounds and stone bit.
  - Shared by both walks.
- The top level holds the FSM, the walk/direction counters, the run accumulator and the bitmaps. Expected size is about 200-300 RTL lines.

## Test plan
- Reset → both bitmaps 0, turn 0, mv_ready 1, game_over 0, move_cnt 0; mv_valid held low for 10 cycles → no change.
- Black (7,3),(7,4),(7,5),(7,6),(7,7) alternating with white (0,0),(0,1),(0,2),(0,3). Ninth move accepted at T → game_over=1, winner=0, draw=0 at T+34; mv_ready stays 0; later mv_valid ignored.
- Black (7,7), then white requests (7,7) → mv_reject pulse at T+1, turn stays 1, move_cnt stays 1. Then white requests row 15 → reject again.
- White (2,6),(3,5),(5,3),(6,2), then (4,4) last → anti-diagonal run 5 built from both walks → winner=1. A variant with black at (6,2) instead → run 4, no win, turn toggles.
- Six-stone horizontal line completed in the middle → win (overline allowed). A four-stone line blocked by the board edge → no win.
- start asserted at T+10 during a scan → at T+11 bitmaps 0, busy 0, mv_ready 1, move_cnt 0, turn 0.

Source files
------------

// File: rtl/gobang_pkg.sv
// gobang_pkg: shared board geometry, FSM/direction enums and cell indexing for the gobang referee.
package gobang_pkg;
   localparam int BOARD_N = 15;
   localparam int CELLS = BOARD_N * BOARD_N;
   localparam int WIN_LEN = 5;
   typedef enum logic [1:0] {IDLE, SCAN, DONE, OVER} state_e;
   typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_e;
   localparam logic signed [4:0] DR_H = 5'sd0, DC_H = 5'sd1;
   localparam logic signed [4:0] DR_V = 5'sd1, DC_V = 5'sd0;
   localparam logic signed [4:0] DR_D = 5'sd1, DC_D = 5'sd1;
   localparam logic signed [4:0] DR_A = 5'sd1, DC_A = -5'sd1;
   function automatic logic signed [4:0] dir_dr(input dir_e d);
      return d == DIR_H ? DR_H : d == DIR_V ? DR_V : d == DIR_D ? DR_D : DR_A;
   endfunction
   function automatic logic signed [4:0] dir_dc(input dir_e d);
      return d == DIR_H ? DC_H : d == DIR_V ? DC_V : d == DIR_D ? DC_D : DC_A;
   endfunction
   function automatic logic [7:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
      return 8'(r) * 8'(BOARD_N) + 8'(c);
   endfunction
endpackage

// File: rtl/gobang_cell_probe.sv
// gobang_cell_probe: bounds test and stone lookup for a signed cursor on one bitmap.
module gobang_cell_probe
   import gobang_pkg::*;
(
   input  logic signed [4:0] row_i,
   input  logic signed [4:0] col_i,
   input  logic [CELLS-1:0]  map_i,
   output logic              in_bounds_o,
   output logic              stone_o
);
   assign in_bounds_o = row_i >= 5'sd0 && row_i <= 5'sd14 && col_i >= 5'sd0 && col_i <= 5'sd14;
   assign stone_o = in_bounds_o & map_i[cell_idx(row_i[3:0], col_i[3:0])];
endmodule

// File: rtl/gobang_referee.sv
// gobang_referee: move handshake, legality check, stone bitmaps and a fixed-latency
// four-direction line scan that decides win, draw or turn change after every move.
module gobang_referee
   import gobang_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mv_valid,
   input  logic [3:0]       mv_row,
   input  logic [3:0]       mv_col,
   output logic             mv_ready,
   output logic             mv_reject,
   output logic [CELLS-1:0] board_black,
   output logic [CELLS-1:0] board_white,
   output logic             turn,
   output logic             busy,
   output logic             game_over,
   output logic             winner,
   output logic             draw,
   output logic [7:0]       move_cnt
);
   state_e state_q, state_d;
   dir_e dir_q, dir_d;
   logic [CELLS-1:0] black_q, black_d, white_q, white_d;
   logic turn_q, turn_d, over_q, over_d, winner_q, winner_d, draw_q, draw_d, rej_q, rej_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] row_q, row_d, col_q, col_d, run_q, run_d, run_n;
   logic signed [4:0] cur_r_q, cur_r_d, cur_c_q, cur_c_d, nr, nc, home_r, home_c;
   logic neg_q, neg_d, brk_q, brk_d, win_q, win_d;
   logic [1:0] step_q, step_d;
   logic [CELLS-1:0] occ, mv_mask;
   logic [7:0] mv_idx;
   logic illegal, inb, stone, hit;
   assign occ = black_q | white_q;
   assign mv_idx = cell_idx(mv_row, mv_col);
   assign mv_mask = CELLS'(1) << mv_idx;
   assign illegal = (mv_row > 4'd14 || mv_col > 4'd14) ? 1'b1 : occ[mv_idx];
   assign home_r = $signed({1'b0, row_q});
   assign home_c = $signed({1'b0, col_q});
   assign nr = cur_r_q + (neg_q ? -dir_dr(dir_q) : dir_dr(dir_q));
   assign nc = cur_c_q + (neg_q ? -dir_dc(dir_q) : dir_dc(dir_q));
   gobang_cell_probe u_probe (
      .row_i(nr),
      .col_i(nc),
      .map_i(turn_q ? white_q : black_q),
      .in_bounds_o(inb),
      .stone_o(stone)
   );
   assign hit = inb & stone;
   assign run_n = run_q + {3'd0, ~brk_q & hit};
   always_comb begin
      state_d = state_q;
      dir_d = dir_q;
      black_d = black_q;
      white_d = white_q;
      turn_d = turn_q;
      over_d = over_q;
      winner_d = winner_q;
      draw_d = draw_q;
      rej_d = 1'b0;
      cnt_d = cnt_q;
      row_d = row_q;
      col_d = col_q;
      run_d = run_q;
      cur_r_d = cur_r_q;
      cur_c_d = cur_c_q;
      neg_d = neg_q;
      brk_d = brk_q;
      win_d = win_q;
      step_d = step_q;
      case (state_q)
         IDLE: if (mv_valid) begin
            if (illegal) rej_d = 1'b1;
            else begin
               black_d = turn_q ? black_q : black_q | mv_mask;
               white_d = turn_q ? white_q | mv_mask : white_q;
               cnt_d = cnt_q + 8'd1;
               row_d = mv_row;
               col_d = mv_col;
               cur_r_d = $signed({1'b0, mv_row});
               cur_c_d = $signed({1'b0, mv_col});
               dir_d = DIR_H;
               neg_d = 1'b1;
               step_d = 2'd0;
               run_d = 4'd0;
               brk_d = 1'b0;
               win_d = 1'b0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            cur_r_d = nr;
            cur_c_d = nc;
            run_d = run_n;
            brk_d = brk_q | ~hit;
            step_d = step_q + 2'd1;
            // last step of a walk: rewind to the new stone; after the positive walk close the direction
            if (step_q == 2'(WIN_LEN - 2)) begin
               cur_r_d = home_r;
               cur_c_d = home_c;
               brk_d = 1'b0;
               neg_d = ~neg_q;
               if (!neg_q) begin
                  run_d = 4'd0;
                  win_d = win_q | (run_n >= 4'(WIN_LEN - 1));
                  dir_d = dir_e'(dir_q + 2'd1);
                  state_d = dir_q == DIR_A ? DONE : SCAN;
               end
            end
         end
         DONE: begin
            if (win_q) begin
               over_d = 1'b1;
               winner_d = turn_q;
               state_d = OVER;
            end else if (cnt_q == 8'(CELLS)) begin
               over_d = 1'b1;
               draw_d = 1'b1;
               state_d = OVER;
            end else begin
               turn_d = ~turn_q;
               state_d = IDLE;
            end
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst || start) begin
         state_q <= IDLE;
         dir_q <= DIR_H;
         black_q <= '0;
         white_q <= '0;
         turn_q <= 1'b0;
         over_q <= 1'b0;
         winner_q <= 1'b0;
         draw_q <= 1'b0;
         rej_q <= 1'b0;
         cnt_q <= 8'd0;
         row_q <= 4'd0;
         col_q <= 4'd0;
         run_q <= 4'd0;
         cur_r_q <= 5'sd0;
         cur_c_q <= 5'sd0;
         neg_q <= 1'b1;
         brk_q <= 1'b0;
         win_q <= 1'b0;
         step_q <= 2'd0;
      end else begin
         state_q <= state_d;
         dir_q <= dir_d;
         black_q <= black_d;
         white_q <= white_d;
         turn_q <= turn_d;
         over_q <= over_d;
         winner_q <= winner_d;
         draw_q <= draw_d;
         rej_q <= rej_d;
         cnt_q <= cnt_d;
         row_q <= row_d;
         col_q <= col_d;
         run_q <= run_d;
         cur_r_q <= cur_r_d;
         cur_c_q <= cur_c_d;
         neg_q <= neg_d;
         brk_q <= brk_d;
         win_q <= win_d;
         step_q <= step_d;
      end
   end
   assign mv_ready = state_q == IDLE;
   assign busy = state_q == SCAN;
   assign mv_reject = rej_q;
   assign board_black = black_q;
   assign board_white = white_q;
   assign turn = turn_q;
   assign game_over = over_q;
   assign winner = winner_q;
   assign draw = draw_q;
   assign move_cnt = cnt_q;
endmodule

// File: tb/tb_gobang_referee.sv
// tb_gobang_referee: table-driven games plus random play checked against a board-array model.
module tb_gobang_referee;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, mv_valid = 1'b0;
   logic [3:0] mv_row = 4'd0, mv_col = 4'd0;
   logic mv_ready, mv_reject, turn, busy, game_over, winner, draw;
   logic [224:0] board_black, board_white;
   logic [7:0] move_cnt;
   always #5 clk = ~clk;
   gobang_referee dut (
      .clk(clk), .rst(rst), .start(start), .mv_valid(mv_valid), .mv_row(mv_row), .mv_col(mv_col),
      .mv_ready(mv_ready), .mv_reject(mv_reject), .board_black(board_black), .board_white(board_white),
      .turn(turn), .busy(busy), .game_over(game_over), .winner(winner), .draw(draw), .move_cnt(move_cnt)
   );
   int n_pass = 0, n_tot = 0;
   int bd[15][15];
   int m_turn, m_cnt, m_over, m_win, m_draw;
   logic last_rej;
   typedef struct {bit ng; int r; int c; bit rej; bit ov; bit w; bit t;} vec_t;
   vec_t tbl[$];
   task automatic chk(input string nm, input logic [224:0] act, input logic [224:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   function automatic logic [224:0] bmap(input int p);
      logic [224:0] b = '0;
      for (int r = 0; r < 15; r++)
         for (int c = 0; c < 15; c++)
            if (bd[r][c] == p) b[r * 15 + c] = 1'b1;
      return b;
   endfunction
   function automatic bit wins(input int r, input int c);
      int dr[4] = '{0, 1, 1, 1};
      int dc[4] = '{1, 0, 1, -1};
      int p = bd[r][c];
      for (int d = 0; d < 4; d++) begin
         int n = 1;
         for (int s = -1; s <= 1; s += 2) begin
            int rr = r + s * dr[d], cc = c + s * dc[d];
            while (rr >= 0 && rr < 15 && cc >= 0 && cc < 15 && bd[rr][cc] == p) begin
               n++;
               rr += s * dr[d];
               cc += s * dc[d];
            end
         end
         if (n >= 5) return 1'b1;
      end
      return 1'b0;
   endfunction
   task automatic m_reset();
      foreach (bd[r, c]) bd[r][c] = 0;
      m_turn = 0; m_cnt = 0; m_over = 0; m_win = 0; m_draw = 0;
   endtask
   task automatic new_game();
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      m_reset();
   endtask
   task automatic play(input int r, input int c);
      bit legal;
      legal = m_over == 0 && r < 15 && c < 15 && bd[r][c] == 0;
      @(negedge clk);
      mv_valid = 1'b1; mv_row = 4'(r); mv_col = 4'(c);
      @(posedge clk) #1 mv_valid = 1'b0;
      @(negedge clk);
      last_rej = mv_reject;
      if (m_over != 0) begin
         chk("over_ready", mv_ready, 0);
         chk("over_cnt", move_cnt, m_cnt);
         chk("over_black", board_black, bmap(1));
         return;
      end
      if (!legal) begin
         chk("rej_pulse", mv_reject, 1);
         chk("rej_ready", mv_ready, 1);
         chk("rej_cnt", move_cnt, m_cnt);
         chk("rej_turn", turn, m_turn);
         @(negedge clk) chk("rej_drop", mv_reject, 0);
         return;
      end
      bd[r][c] = m_turn + 1;
      m_cnt++;
      chk("black_map", board_black, bmap(1));
      chk("white_map", board_white, bmap(2));
      chk("busy_first", busy, 1);
      chk("ready_scan", mv_ready, 0);
      chk("cnt_acc", move_cnt, m_cnt);
      repeat (31) @(negedge clk);
      chk("busy_last", busy, 1);
      @(negedge clk);
      chk("busy_done", busy, 0);
      chk("ready_done", mv_ready, 0);
      if (wins(r, c)) begin m_over = 1; m_win = m_turn; end
      else if (m_cnt == 225) begin m_over = 1; m_draw = 1; end
      else m_turn ^= 1;
      @(negedge clk);
      chk("turn", turn, m_turn);
      chk("game_over", game_over, m_over);
      chk("winner", winner, m_win);
      chk("draw", draw, m_draw);
      chk("ready_after", mv_ready, m_over == 0);
   endtask
   task automatic add(input bit ng, input int r, input int c, input bit rej, input bit ov, input bit w, input bit t);
      vec_t v;
      v = '{ng, r, c, rej, ov, w, t};
      tbl.push_back(v);
   endtask
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      m_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("rst_black", board_black, 0);
      chk("rst_white", board_white, 0);
      chk("rst_turn", turn, 0);
      chk("rst_ready", mv_ready, 1);
      chk("rst_over", game_over, 0);
      chk("rst_cnt", move_cnt, 0);
      chk("rst_busy", busy, 0);
      repeat (10) @(negedge clk);
      chk("idle_ready", mv_ready, 1);
      chk("idle_cnt", move_cnt, 0);
      chk("idle_black", board_black, 0);
      // horizontal five for black
      add(1, 7, 3, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 0); add(0, 7, 4, 0, 0, 0, 1); add(0, 0, 1, 0, 0, 0, 0);
      add(0, 7, 5, 0, 0, 0, 1); add(0, 0, 2, 0, 0, 0, 0); add(0, 7, 6, 0, 0, 0, 1); add(0, 0, 3, 0, 0, 0, 0);
      add(0, 7, 7, 0, 1, 0, 0);
      // occupied cell and out-of-range rejects, corner move
      add(1, 7, 7, 0, 0, 0, 1); add(0, 7, 7, 1, 0, 0, 1); add(0, 15, 0, 1, 0, 0, 1); add(0, 3, 15, 1, 0, 0, 1);
      add(0, 14, 14, 0, 0, 0, 0);
      // anti-diagonal five for white, closed in the middle
      add(1, 10, 0, 0, 0, 0, 1); add(0, 2, 6, 0, 0, 0, 0); add(0, 10, 2, 0, 0, 0, 1); add(0, 3, 5, 0, 0, 0, 0);
      add(0, 10, 4, 0, 0, 0, 1); add(0, 5, 3, 0, 0, 0, 0); add(0, 10, 6, 0, 0, 0, 1); add(0, 6, 2, 0, 0, 0, 0);
      add(0, 12, 0, 0, 0, 0, 1); add(0, 4, 4, 0, 1, 1, 1);
      // same shape with (6,2) black: only four
      add(1, 6, 2, 0, 0, 0, 1); add(0, 2, 6, 0, 0, 0, 0); add(0, 10, 0, 0, 0, 0, 1); add(0, 3, 5, 0, 0, 0, 0);
      add(0, 10, 2, 0, 0, 0, 1); add(0, 5, 3, 0, 0, 0, 0); add(0, 10, 4, 0, 0, 0, 1); add(0, 4, 4, 0, 0, 0, 0);
      // overline of six completed in the middle
      add(1, 5, 0, 0, 0, 0, 1); add(0, 14, 0, 0, 0, 0, 0); add(0, 5, 1, 0, 0, 0, 1); add(0, 14, 2, 0, 0, 0, 0);
      add(0, 5, 2, 0, 0, 0, 1); add(0, 14, 4, 0, 0, 0, 0); add(0, 5, 4, 0, 0, 0, 1); add(0, 14, 6, 0, 0, 0, 0);
      add(0, 5, 5, 0, 0, 0, 1); add(0, 14, 8, 0, 0, 0, 0); add(0, 5, 3, 0, 1, 0, 0);
      // four against the right edge
      add(1, 0, 11, 0, 0, 0, 1); add(0, 9, 0, 0, 0, 0, 0); add(0, 0, 12, 0, 0, 0, 1); add(0, 9, 2, 0, 0, 0, 0);
      add(0, 0, 13, 0, 0, 0, 1); add(0, 9, 4, 0, 0, 0, 0); add(0, 0, 14, 0, 0, 0, 1);
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].ng) new_game();
         play(tbl[i].r, tbl[i].c);
         chk("tbl_rej", last_rej, tbl[i].rej);
         chk("tbl_over", game_over, tbl[i].ov);
         chk("tbl_winner", winner, tbl[i].w);
         chk("tbl_turn", turn, tbl[i].t);
         if (m_over != 0) play(1, 1);
      end
      // start aborts a scan in flight
      new_game();
      @(negedge clk);
      mv_valid = 1'b1; mv_row = 4'd7; mv_col = 4'd7;
      @(posedge clk) #1 mv_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("pre_abort_busy", busy, 1);
      start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      @(negedge clk);
      chk("abort_black", board_black, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", mv_ready, 1);
      chk("abort_cnt", move_cnt, 0);
      chk("abort_turn", turn, 0);
      m_reset();
      // a move offered together with start is dropped
      @(negedge clk);
      start = 1'b1; mv_valid = 1'b1; mv_row = 4'd3; mv_col = 4'd3;
      @(posedge clk) #1 begin start = 1'b0; mv_valid = 1'b0; end
      @(negedge clk);
      chk("start_mv_cnt", move_cnt, 0);
      chk("start_mv_black", board_black, 0);
      chk("start_mv_busy", busy, 0);
      // random games in a 7x7 window with occasional out-of-range requests
      for (int g = 0; g < 3; g++) begin
         new_game();
         for (int k = 0; k < 60 && m_over == 0; k++) begin
            int r, c;
            r = $urandom_range(0, 19) == 0 ? 15 : $urandom_range(4, 10);
            c = $urandom_range(0, 19) == 0 ? 15 : $urandom_range(4, 10);
            play(r, c);
         end
         chk("rand_cnt", move_cnt, m_cnt);
         chk("rand_black", board_black, bmap(1));
         chk("rand_white", board_white, bmap(2));
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
